// File: rtl/packet_presence_detection_pretrig.sv
// Packet presence detector: short moving-average envelope against an adaptive
// noise floor, forwarding a bounded window that includes pre-trigger history.
module packet_presence_detection_pretrig #(
  parameter int unsigned IQ_WIDTH     = 12,
  parameter int unsigned SHORT_LOG2   = 3,
  parameter int unsigned LONG_LOG2    = 8,
  parameter int unsigned PRETRIG_LOG2 = 4
) (
  input  logic                    clock_sink_clk,
  input  logic                    reset_sink_reset,
  input  logic [2*IQ_WIDTH-1:0]   avalon_streaming_sink_data,
  input  logic                    avalon_streaming_sink_valid,
  output logic [2*IQ_WIDTH-1:0]   avalon_streaming_source_data,
  output logic                    avalon_streaming_source_valid,
  input  logic                    cfg_enable,
  input  logic                    cfg_clear_rs,
  input  logic [7:0]              cfg_threshold,
  input  logic [15:0]             cfg_passthrough_len,
  input  logic                    cfg_freeze_long,
  output logic [31:0]             debug_count,
  output logic [31:0]             debug_short_sum,
  output logic [31:0]             debug_long_sum,
  output logic [1:0]              debug_state
);

  localparam int unsigned DW  = 2 * IQ_WIDTH;
  localparam int unsigned MW  = IQ_WIDTH + 1;
  localparam int unsigned SW  = MW + SHORT_LOG2;
  localparam int unsigned LW  = MW + LONG_LOG2;
  localparam int unsigned TW  = IQ_WIDTH + 9;
  localparam int unsigned SN  = 2 ** SHORT_LOG2;
  localparam int unsigned PN  = 2 ** PRETRIG_LOG2;
  localparam int unsigned SLW = SN * MW;
  localparam int unsigned PLW = PN * DW;
  localparam int unsigned CW  = ((PRETRIG_LOG2 > 16) ? PRETRIG_LOG2 : 16) + 1;
  localparam int unsigned WW  = LONG_LOG2 + 1;
  localparam logic [WW-1:0] WARM_LAST = WW'(2 ** LONG_LOG2 - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WARMUP = 2'd1;
  localparam logic [1:0] ST_SEARCH = 2'd2;
  localparam logic [1:0] ST_PASS   = 2'd3;

  logic [1:0]                state;
  logic [SW-1:0]             short_sum;
  logic [SW-1:0]             short_next;
  logic [LW-1:0]             long_sum;
  logic [LW-1:0]             long_next;
  logic [SLW-1:0]            short_line;
  logic [PLW-1:0]            pre_line;
  logic [WW-1:0]             warm_cnt;
  logic [CW-1:0]             remaining;
  logic [CW-1:0]             win_len;
  logic                      trig;
  logic                      trig_r;
  logic signed [IQ_WIDTH-1:0] s_i;
  logic signed [IQ_WIDTH-1:0] s_q;
  logic [MW-1:0]             abs_i;
  logic [MW-1:0]             abs_q;
  logic [MW-1:0]             mag;
  logic [MW-1:0]             mag_oldest;
  logic [MW-1:0]             short_avg;
  logic [MW-1:0]             long_avg;
  logic [DW-1:0]             pre_oldest;

  always_comb begin
    s_i        = $signed(avalon_streaming_sink_data[DW-1:IQ_WIDTH]);
    s_q        = $signed(avalon_streaming_sink_data[IQ_WIDTH-1:0]);
    abs_i      = s_i[IQ_WIDTH-1] ? ({1'b0, ~s_i} + MW'(1)) : {1'b0, s_i};
    abs_q      = s_q[IQ_WIDTH-1] ? ({1'b0, ~s_q} + MW'(1)) : {1'b0, s_q};
    mag        = abs_i + abs_q;
    mag_oldest = short_line[SLW-1 -: MW];
    pre_oldest = pre_line[PLW-1 -: DW];
    short_next = short_sum + SW'(mag) - SW'(mag_oldest);

    // Warm-up fills the floor with a plain boxcar sum so it starts as an exact
    // 2^LONG_LOG2-sample average; the EMA decay only applies afterwards.
    if (state == ST_WARMUP) begin
      long_next = long_sum + LW'(mag);
    end else if ((state == ST_PASS) && cfg_freeze_long) begin
      long_next = long_sum;
    end else begin
      long_next = long_sum + LW'(mag) - (long_sum >> LONG_LOG2);
    end

    short_avg = MW'(short_next >> SHORT_LOG2);
    long_avg  = MW'(long_next >> LONG_LOG2);
    trig      = (TW'(short_avg) << 4) > (TW'(long_avg) * TW'(cfg_threshold));
    win_len   = CW'(PN) + CW'(cfg_passthrough_len);
  end

  always_ff @(posedge clock_sink_clk) begin
    if (reset_sink_reset) begin
      state                         <= ST_IDLE;
      short_sum                     <= '0;
      long_sum                      <= '0;
      short_line                    <= '0;
      pre_line                      <= '0;
      warm_cnt                      <= '0;
      remaining                     <= '0;
      trig_r                        <= 1'b0;
      debug_count                   <= '0;
      avalon_streaming_source_data  <= '0;
      avalon_streaming_source_valid <= 1'b0;
    end else if (cfg_clear_rs || !cfg_enable || (state == ST_IDLE)) begin
      // Clear, bypass and the IDLE->WARMUP step all leave the datapath zeroed.
      short_sum  <= '0;
      long_sum   <= '0;
      short_line <= '0;
      pre_line   <= '0;
      warm_cnt   <= '0;
      remaining  <= '0;
      trig_r     <= 1'b0;
      if (cfg_clear_rs) begin
        debug_count <= '0;
      end
      state <= cfg_enable ? ST_WARMUP : ST_IDLE;
      if (!cfg_enable) begin
        avalon_streaming_source_valid <= avalon_streaming_sink_valid;
        if (avalon_streaming_sink_valid) begin
          avalon_streaming_source_data <= avalon_streaming_sink_data;
        end
      end else begin
        avalon_streaming_source_valid <= 1'b0;
      end
    end else begin
      avalon_streaming_source_valid <= 1'b0;
      if (avalon_streaming_sink_valid) begin
        short_sum  <= short_next;
        long_sum   <= long_next;
        short_line <= (short_line << MW) | SLW'(mag);
        pre_line   <= (pre_line << DW) | PLW'(avalon_streaming_sink_data);
        case (state)
          ST_WARMUP: begin
            trig_r   <= 1'b0;
            warm_cnt <= warm_cnt + WW'(1);
            if (warm_cnt == WARM_LAST) begin
              state <= ST_SEARCH;
            end
          end
          ST_SEARCH: begin
            trig_r <= trig;
            if (trig_r) begin
              if (debug_count != '1) begin
                debug_count <= debug_count + 32'd1;
              end
              avalon_streaming_source_valid <= 1'b1;
              avalon_streaming_source_data  <= pre_oldest;
              // The entry sample is the first of the window.
              remaining <= win_len - CW'(1);
              if (win_len != CW'(1)) begin
                state <= ST_PASS;
              end
            end
          end
          ST_PASS: begin
            trig_r                        <= trig;
            avalon_streaming_source_valid <= 1'b1;
            avalon_streaming_source_data  <= pre_oldest;
            remaining                     <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              state <= ST_SEARCH;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign debug_short_sum = 32'(short_sum);
  assign debug_long_sum  = 32'(long_sum);
  assign debug_state     = state;

endmodule

// File: tb/tb_packet_presence_detection_pretrig.sv
// Bench for packet_presence_detection_pretrig: directed scenarios plus random
// traffic, checked every cycle against a sample-history reference model.
module tb_packet_presence_detection_pretrig;

  localparam int W  = 12;
  localparam int S  = 3;
  localparam int L  = 8;
  localparam int PL = 4;
  localparam int P  = 16;
  localparam int SN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] din = '0;
  logic        v   = 1'b0;
  logic        en  = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  thr = '0;
  logic [15:0] len = '0;
  logic        frz = 1'b0;
  logic [23:0] src_data;
  logic        src_valid;
  logic [31:0] dbg_count, dbg_short, dbg_long;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  packet_presence_detection_pretrig #(
    .IQ_WIDTH(W), .SHORT_LOG2(S), .LONG_LOG2(L), .PRETRIG_LOG2(PL)
  ) dut (
    .clock_sink_clk(clk),
    .reset_sink_reset(rst),
    .avalon_streaming_sink_data(din),
    .avalon_streaming_sink_valid(v),
    .avalon_streaming_source_data(src_data),
    .avalon_streaming_source_valid(src_valid),
    .cfg_enable(en),
    .cfg_clear_rs(clr),
    .cfg_threshold(thr),
    .cfg_passthrough_len(len),
    .cfg_freeze_long(frz),
    .debug_count(dbg_count),
    .debug_short_sum(dbg_short),
    .debug_long_sum(dbg_long),
    .debug_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input int i, input int q);
    logic [11:0] a, b;
    a = i[11:0];
    b = q[11:0];
    return {a, b};
  endfunction

  function automatic int mag_of(input logic [23:0] s);
    logic signed [11:0] si, sq;
    int a, b;
    si = s[23:12];
    sq = s[11:0];
    a = int'(si);
    b = int'(sq);
    return ((a < 0) ? -a : a) + ((b < 0) ? -b : b);
  endfunction

  function automatic logic [23:0] wsamp(input int k);
    return mk((k % 3 == 0) ? -10 : 10, 0);
  endfunction

  function automatic logic [23:0] hsamp(input int j);
    return mk((j % 2 == 0) ? 100 : -100, 0);
  endfunction

  // Reference model: states 0..3 = IDLE, WARMUP, SEARCH, PASS.
  logic [23:0] hist[$];
  int          m_state = 0;
  longint      m_long  = 0;
  longint      m_short = 0;
  longint      m_cnt   = 0;
  int          m_warm  = 0;
  int          m_rem   = 0;
  bit          m_tp    = 0;
  bit          e_valid = 0;
  logic [23:0] e_data  = '0;
  logic [23:0] m_delayed;
  int          m_mag;
  bit          m_t;

  function automatic longint short_of();
    longint s = 0;
    for (int k = 0; k < SN && k < hist.size(); k++) s += mag_of(hist[hist.size() - 1 - k]);
    return s;
  endfunction

  task automatic model_zero();
    hist.delete();
    m_long = 0; m_short = 0; m_warm = 0; m_rem = 0; m_tp = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_zero();
      m_state = 0; m_cnt = 0; e_valid = 0; e_data = '0;
    end else if (clr || !en || m_state == 0) begin
      model_zero();
      if (clr) m_cnt = 0;
      m_state = en ? 1 : 0;
      if (!en) begin
        e_valid = v;
        if (v) e_data = din;
      end else begin
        e_valid = 0;
      end
    end else begin
      e_valid = 0;
      if (v) begin
        m_delayed = (hist.size() >= P) ? hist[hist.size() - P] : 24'd0;
        hist.push_back(din);
        if (hist.size() > 64) void'(hist.pop_front());
        m_mag = mag_of(din);
        if (m_state == 1) m_long = m_long + m_mag;
        else if (!(m_state == 3 && frz)) m_long = m_long + m_mag - (m_long >> L);
        m_short = short_of();
        m_t = ((m_short >> S) * 16) > ((m_long >> L) * longint'(thr));
        case (m_state)
          1: begin
            m_warm++;
            if (m_warm == (1 << L)) m_state = 2;
            m_tp = 0;
          end
          2: begin
            if (m_tp) begin
              if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
              e_valid = 1;
              e_data  = m_delayed;
              m_rem   = P + int'(len) - 1;
              if (m_rem > 0) m_state = 3;
            end
            m_tp = m_t;
          end
          default: begin
            e_valid = 1;
            e_data  = m_delayed;
            m_rem--;
            if (m_rem == 0) m_state = 2;
            m_tp = m_t;
          end
        endcase
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("src_valid", src_valid, e_valid);
    if (e_valid) chk("src_data", src_data, e_data);
    chk("state", dbg_state, m_state);
    chk("count", dbg_count, m_cnt);
    chk("short_sum", dbg_short, m_short);
    chk("long_sum", dbg_long, m_long);
  end

  logic [23:0] outq[$];

  task automatic step(input bit vv, input logic [23:0] d);
    @(negedge clk);
    v   = vv;
    din = d;
    @(posedge clk);
    #2;
    if (src_valid) outq.push_back(src_data);
  endtask

  task automatic warm(input bit gaps);
    for (int k = 0; k < 256; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(0, 24'($urandom));
      step(1, wsamp(k));
    end
  endtask

  task automatic window_run(input bit gaps, input string tag);
    longint frozen = 0;
    bit     have   = 0;
    outq.delete();
    for (int j = 0; j < 38; j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step(0, 24'($urandom));
      step(1, hsamp(j));
      if (j == 1) begin
        chk({tag, "_not_yet_pass"}, dbg_state, 2);
        chk({tag, "_count_before"}, dbg_count, gaps ? 0 : 0);
      end
      if (j == 2) chk({tag, "_pass_entry"}, dbg_state, 3);
      if (gaps && dbg_state == 3) begin
        if (!have) begin
          frozen = m_long;
          have = 1;
        end else begin
          chk({tag, "_long_frozen"}, dbg_long, frozen);
        end
      end
    end
    chk({tag, "_win_len"}, outq.size(), 36);
    chk({tag, "_state_after"}, dbg_state, 2);
    if (outq.size() >= 36) begin
      chk({tag, "_first_out"}, outq[0], 24'h00A000);
      chk({tag, "_first_high"}, outq[14], 24'h064000);
      for (int i = 0; i < 36; i++)
        chk({tag, "_win_data"}, outq[i], (i < 14) ? wsamp(242 + i) : hsamp(i - 14));
    end
  endtask

  logic [23:0] x;
  int          mode;

  initial begin
    // Reset and bypass
    repeat (3) step(0, 24'h0);
    chk("rst_valid", src_valid, 0);
    chk("rst_data", src_data, 0);
    chk("rst_count", dbg_count, 0);
    chk("rst_short", dbg_short, 0);
    chk("rst_long", dbg_long, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      x = 24'($urandom);
      step(1, x);
      chk("bypass_valid", src_valid, 1);
      chk("bypass_data", src_data, x);
    end
    chk("bypass_count", dbg_count, 0);

    // Warm-up
    thr = 8'h00; len = 16'd20; frz = 1'b0; en = 1'b1;
    step(0, 24'h0);
    chk("warm_state", dbg_state, 1);
    warm(0);
    chk("warm_done", dbg_state, 2);
    chk("warm_long", dbg_long, 2560);
    chk("warm_short", dbg_short, 80);

    // Detection, window, retrigger
    thr = 8'h30;
    window_run(0, "nogap");
    chk("count_1", dbg_count, 1);
    step(1, hsamp(38));
    chk("retrig_state", dbg_state, 3);
    chk("count_2", dbg_count, 2);
    for (int j = 39; j < 44; j++) step(1, hsamp(j));

    // Enable drop mid-PASS, then clear
    en = 1'b0;
    x = mk(123, -45);
    step(1, x);
    chk("abort_valid", src_valid, 1);
    chk("abort_data", src_data, x);
    chk("abort_state", dbg_state, 0);
    en = 1'b1; clr = 1'b1;
    step(1, x);
    clr = 1'b0;
    chk("clr_short", dbg_short, 0);
    chk("clr_long", dbg_long, 0);
    chk("clr_count", dbg_count, 0);
    chk("clr_state", dbg_state, 1);

    // Valid gaps with floor freeze
    thr = 8'h00; frz = 1'b1;
    warm(1);
    chk("gap_warm_long", dbg_long, 2560);
    thr = 8'h30;
    window_run(1, "gap");
    chk("gap_count", dbg_count, 1);

    // Random traffic
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) mode = 1 - mode;
      if ($urandom_range(0, 199) == 0) thr = 8'($urandom_range(16, 64));
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: len = 16'd0;
          1: len = 16'd1;
          2: len = 16'($urandom_range(2, 30));
          default: len = 16'd40;
        endcase
      end
      if ($urandom_range(0, 149) == 0) frz = ~frz;
      en  = ($urandom_range(0, 499) != 0);
      clr = ($urandom_range(0, 799) == 0);
      if (mode == 0)
        x = mk(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20);
      else if ($urandom_range(0, 19) == 0)
        x = mk(-2048, -2048);
      else
        x = mk(int'($urandom_range(0, 3000)) - 1500, int'($urandom_range(0, 3000)) - 1500);
      step($urandom_range(0, 3) != 0, x);
    end
    clr = 1'b0; en = 1'b1;
    step(0, 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
